// File: rtl/regx_arb.sv
// Two-port arbiter for the Xdata register bus: port A (MCU, high priority) and port B (I2C/debug,
// anti-starvation). Optional port-B write protection is enabled by defining REGX_ARB_WPROT_EN.
module regx_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [6:0]  PROT_BASE  = 7'h10
) (
  input  logic       clk,
  input  logic       rrst,

  input  logic       a_req,
  input  logic       a_wr,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_wdat,
  output logic       a_ack,
  output logic [7:0] a_rdat,

  input  logic       b_req,
  input  logic       b_wr,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_wdat,
  output logic       b_ack,
  output logic [7:0] b_rdat,
  output logic       b_err,

  input  logic       wprot_unlock,

  output logic       regx_r,
  output logic       regx_w,
  output logic [6:0] regx_addr,
  output logic [7:0] regx_wdat,
  input  logic [7:0] regx_rdat
);

  typedef enum logic [1:0] {IDLE, ACC, RDAT, DONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nx;
  logic       pend_a, pend_b;
  logic       hold_a_wr, hold_b_wr;
  logic [6:0] hold_a_addr, hold_b_addr;
  logic [7:0] hold_a_wdat, hold_b_wdat;
  logic       bus_wr;
  logic       bus_owner;   // 0 = port A, 1 = port B
  logic [3:0] starve_cnt, starve_nx;

  logic       eff_a, eff_b;
  logic       grant_a, grant_b;
  logic       done_a, done_b;
  logic       cap_a, cap_b;
  logic       sel_wr;
  logic [6:0] sel_addr;
  logic [7:0] sel_wdat;
  logic       wp_block;

  // A request arriving in IDLE is arbitrated in the same cycle, which gives the +1 bus latency.
  assign eff_a  = pend_a | a_req;
  assign eff_b  = pend_b | b_req;
  assign done_a = (state == DONE) && !bus_owner;
  assign done_b = (state == DONE) &&  bus_owner;
  assign cap_a  = a_req && (!pend_a || done_a);
  assign cap_b  = b_req && (!pend_b || done_b);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    unique case (state)
      IDLE: begin
        if (eff_a && (!eff_b || starve_cnt != STARVE_LIM)) begin
          grant_a  = 1'b1;
          state_nx = ACC;
        end else if (eff_b) begin
          grant_b  = 1'b1;
          state_nx = ACC;
        end
      end
      ACC:     state_nx = bus_wr ? DONE : RDAT;
      RDAT:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if (grant_b) begin
      sel_wr   = pend_b ? hold_b_wr   : b_wr;
      sel_addr = pend_b ? hold_b_addr : b_addr;
      sel_wdat = pend_b ? hold_b_wdat : b_wdat;
    end else begin
      sel_wr   = pend_a ? hold_a_wr   : a_wr;
      sel_addr = pend_a ? hold_a_addr : a_addr;
      sel_wdat = pend_a ? hold_a_wdat : a_wdat;
    end
  end

  always_comb begin
    if (grant_b)
      starve_nx = 4'd0;
    else if (grant_a && eff_b)
      starve_nx = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
    else if (!pend_b)
      starve_nx = 4'd0;
    else
      starve_nx = starve_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rrst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rrst) begin
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      hold_a_wr   <= 1'b0;
      hold_a_addr <= '0;
      hold_a_wdat <= '0;
      hold_b_wr   <= 1'b0;
      hold_b_addr <= '0;
      hold_b_wdat <= '0;
      bus_wr      <= 1'b0;
      bus_owner   <= 1'b0;
      regx_addr   <= '0;
      regx_wdat   <= '0;
      a_rdat      <= '0;
      b_rdat      <= '0;
      starve_cnt  <= '0;
    end else begin
      // A re-request in the ack cycle wins over the clear.
      if (cap_a) begin
        pend_a      <= 1'b1;
        hold_a_wr   <= a_wr;
        hold_a_addr <= a_addr;
        hold_a_wdat <= a_wdat;
      end else if (done_a) begin
        pend_a      <= 1'b0;
      end
      if (cap_b) begin
        pend_b      <= 1'b1;
        hold_b_wr   <= b_wr;
        hold_b_addr <= b_addr;
        hold_b_wdat <= b_wdat;
      end else if (done_b) begin
        pend_b      <= 1'b0;
      end
      if (grant_a || grant_b) begin
        bus_owner <= grant_b;
        bus_wr    <= sel_wr;
        regx_addr <= sel_addr;
        regx_wdat <= sel_wdat;
      end
      if (state == RDAT) begin
        if (bus_owner) b_rdat <= regx_rdat;
        else           a_rdat <= regx_rdat;
      end
      starve_cnt <= starve_nx;
    end
  end

`ifdef REGX_ARB_WPROT_EN
  logic bus_err;

  assign wp_block = (state == ACC) && bus_owner && bus_wr &&
                    (regx_addr >= PROT_BASE) && !wprot_unlock;

  always_ff @(posedge clk) begin
    if (rrst)               bus_err <= 1'b0;
    else if (state == ACC)  bus_err <= wp_block;
  end

  assign b_err = done_b && bus_err;
`else
  logic unused_wprot;

  assign wp_block     = 1'b0;
  assign unused_wprot = wprot_unlock | (|PROT_BASE);
  assign b_err        = 1'b0;
`endif

  assign regx_r = (state == ACC) && !bus_wr;
  assign regx_w = (state == ACC) &&  bus_wr && !wp_block;
  assign a_ack  = done_a;
  assign b_ack  = done_b;

endmodule

// File: tb/tb_regx_arb.sv
// Self-checking bench for regx_arb: directed protocol steps followed by a randomized phase
// scored against a transaction-level register-file model.
module tb_regx_arb;

  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       rrst;
  logic       a_req, a_wr, a_ack;
  logic [6:0] a_addr;
  logic [7:0] a_wdat, a_rdat;
  logic       b_req, b_wr, b_ack, b_err;
  logic [6:0] b_addr;
  logic [7:0] b_wdat, b_rdat;
  logic       wprot_unlock;
  logic       regx_r, regx_w;
  logic [6:0] regx_addr;
  logic [7:0] regx_wdat, regx_rdat;

  always #5 clk = ~clk;

  regx_arb dut (
    .clk(clk), .rrst(rrst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdat(a_wdat), .a_ack(a_ack), .a_rdat(a_rdat),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdat(b_wdat), .b_ack(b_ack), .b_rdat(b_rdat),
    .b_err(b_err), .wprot_unlock(wprot_unlock),
    .regx_r(regx_r), .regx_w(regx_w), .regx_addr(regx_addr), .regx_wdat(regx_wdat),
    .regx_rdat(regx_rdat)
  );

  // Register file with a registered read; the bench preloads it through its own write port.
  logic [7:0] rf [128];
  logic       tb_wr;
  logic [6:0] tb_waddr;
  logic [7:0] tb_wdata;

  always @(posedge clk) begin
    if (tb_wr)       rf[tb_waddr]  <= tb_wdata;
    else if (regx_w) rf[regx_addr] <= regx_wdat;
    if (regx_r) regx_rdat <= rf[regx_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic load_rf(input logic [6:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
    step;
    tb_wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] gold [128];
  logic [6:0] order[$];
  logic [6:0] exp_order[$];
  int         a_iss, a_acks, quiet;
  logic       b_done;
  logic       busy_a, busy_b, ea_wr, eb_wr;
  logic [6:0] ea_addr, eb_addr;
  logic [7:0] ea_dat, eb_dat;
  int         wait_a, wait_b, a_since_b;

  initial begin
    rrst = 1'b1; wprot_unlock = 1'b0; tb_wr = 1'b0; tb_waddr = '0; tb_wdata = '0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdat = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdat = '0;

    // Reset state
    step; step;
    chk("reset_outs", {a_ack, b_ack, b_err, regx_r, regx_w, regx_addr, regx_wdat, a_rdat, b_rdat}, 64'd0);
    rrst = 1'b0;
    step;
    chk("reset_idle", {regx_r, regx_w, a_ack, b_ack}, 64'd0);

    // Port A write; a second a_req while pending must be ignored
    a_req = 1'b1; a_wr = 1'b1; a_addr = 7'h04; a_wdat = 8'h5A;
    step;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 7'h7F;
    chk("aw_strobe", {regx_w, regx_r}, 64'b10);
    chk("aw_bus", {regx_addr, regx_wdat}, {7'h04, 8'h5A});
    chk("aw_noack", {a_ack, b_ack}, 64'd0);
    step;
    a_req = 1'b0;
    chk("aw_ack", {a_ack, b_ack, regx_w}, 64'b100);
    step;
    chk("aw_pulse", {a_ack, regx_w, regx_r}, 64'd0);
    chk("aw_hold", {regx_addr, regx_wdat}, {7'h04, 8'h5A});
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (regx_r || regx_w || a_ack) quiet++;
    end
    chk("aw_ignored_req", quiet, 0);

    // Port B read with data returned the cycle after regx_r
    load_rf(7'h13, 8'hC3);
    b_req = 1'b1; b_wr = 1'b0; b_addr = 7'h13; b_wdat = 8'hFF;
    step;
    b_req = 1'b0;
    chk("br_strobe", {regx_r, regx_w}, 64'b10);
    chk("br_addr", regx_addr, 7'h13);
    step;
    chk("br_rdat_cycle", {b_ack, regx_r, regx_w}, 64'd0);
    step;
    chk("br_ack", {b_ack, b_err, a_ack}, 64'b100);
    chk("br_data", b_rdat, 8'hC3);
    chk("br_a_rdat_kept", a_rdat, 8'h00);
    step;

    // Collision: A first, then B after the mandatory idle cycle
    a_req = 1'b1; a_wr = 1'b1; a_addr = 7'h05; a_wdat = 8'h11;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 7'h06; b_wdat = 8'h22;
    step;
    a_req = 1'b0; b_req = 1'b0;
    chk("col_first", {regx_w, regx_addr, regx_wdat}, {1'b1, 7'h05, 8'h11});
    step;
    chk("col_a_ack", {a_ack, b_ack}, 64'b10);
    step;
    chk("col_gap", {regx_w, regx_r, a_ack, b_ack}, 64'd0);
    step;
    chk("col_second", {regx_w, regx_addr, regx_wdat}, {1'b1, 7'h06, 8'h22});
    step;
    chk("col_b_ack", {a_ack, b_ack, b_err}, 64'b010);
    step;

    // Starvation: A re-requests on every ack while B waits
    a_req = 1'b1; a_wr = 1'b1; a_addr = 7'h30; a_wdat = 8'h80;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 7'h20;
    a_iss = 1; a_acks = 0; b_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !(b_done && a_acks == 6); cyc++) begin
      step;
      a_req = 1'b0; b_req = 1'b0;
      if (regx_w || regx_r) order.push_back(regx_addr);
      if (b_ack) b_done = 1'b1;
      if (a_ack) begin
        a_acks++;
        if (a_iss < 6) begin
          a_req = 1'b1; a_addr = 7'(48 + a_iss); a_wdat = 8'(a_iss);
          a_iss++;
        end
      end
    end
    for (int k = 0; k < STARVE_MAX; k++) exp_order.push_back(7'(48 + k));
    exp_order.push_back(7'h20);
    for (int k = STARVE_MAX; k < 6; k++) exp_order.push_back(7'(48 + k));
    chk("starve_done", {b_done, 7'(a_acks)}, {1'b1, 7'd6});
    chk("starve_len", order.size(), exp_order.size());
    for (int i = 0; i < order.size() && i < exp_order.size(); i++)
      chk($sformatf("starve_grant_%0d", i), order[i], exp_order[i]);
    step; step;

    // Reset in the RDAT cycle with port B also pending
    a_req = 1'b1; a_wr = 1'b0; a_addr = 7'h07;
    step;
    a_req = 1'b0;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 7'h41;
    chk("rst_acc", {regx_r, regx_addr}, {1'b1, 7'h07});
    step;
    b_req = 1'b0; rrst = 1'b1;
    step;
    rrst = 1'b0;
    chk("rst_outs", {a_ack, b_ack, b_err, regx_r, regx_w, a_rdat, b_rdat}, 64'd0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (regx_r || regx_w || a_ack || b_ack) quiet++;
    end
    chk("rst_pend_clear", quiet, 0);

`ifdef REGX_ARB_WPROT_EN
    wprot_unlock = 1'b0;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 7'h1A; b_wdat = 8'h66;
    step;
    b_req = 1'b0;
    chk("wp_blocked", {regx_w, regx_r}, 64'd0);
    step;
    chk("wp_err", {b_ack, b_err}, 64'b11);
    step;
    wprot_unlock = 1'b1;
    b_req = 1'b1;
    step;
    b_req = 1'b0;
    chk("wp_unlocked", {regx_w, regx_addr, regx_wdat}, {1'b1, 7'h1A, 8'h66});
    step;
    chk("wp_ok", {b_ack, b_err}, 64'b10);
    step;
`else
    wprot_unlock = 1'b0;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 7'h1A; b_wdat = 8'h66;
    step;
    b_req = 1'b0;
    chk("nowp_write", {regx_w, regx_addr, regx_wdat}, {1'b1, 7'h1A, 8'h66});
    step;
    chk("nowp_ack", {b_ack, b_err}, 64'b10);
    step;
`endif

    // Randomized traffic: A owns addresses 0x00-0x3F, B owns 0x40-0x7F
    wprot_unlock = 1'b1;
    for (int i = 0; i < 128; i++) begin
      gold[i] = 8'($urandom);
      load_rf(7'(i), gold[i]);
    end
    busy_a = 1'b0; busy_b = 1'b0; wait_a = 0; wait_b = 0; a_since_b = 0;
    ea_wr = 1'b0; eb_wr = 1'b0; ea_addr = '0; eb_addr = '0; ea_dat = '0; eb_dat = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step;
      a_req = 1'b0; b_req = 1'b0;
      chk("rand_excl", regx_r && regx_w, 1'b0);
      if (a_ack) begin
        chk("rand_a_expected", busy_a, 1'b1);
        if (busy_a && !ea_wr) chk("rand_a_rdat", a_rdat, gold[ea_addr]);
        if (busy_a && ea_wr)  gold[ea_addr] = ea_dat;
        if (busy_b) a_since_b++;
        busy_a = 1'b0;
      end
      if (b_ack) begin
        chk("rand_b_expected", busy_b, 1'b1);
        chk("rand_b_err", b_err, 1'b0);
        chk("rand_starve_bound", a_since_b <= STARVE_MAX + 1, 1'b1);
        if (busy_b && !eb_wr) chk("rand_b_rdat", b_rdat, gold[eb_addr]);
        if (busy_b && eb_wr)  gold[eb_addr] = eb_dat;
        busy_b = 1'b0;
      end
      if (busy_a) begin
        wait_a++;
        if (wait_a > 40) begin
          chk("rand_a_timeout", wait_a, 40);
          busy_a = 1'b0;
        end
      end
      if (busy_b) begin
        wait_b++;
        if (wait_b > 40) begin
          chk("rand_b_timeout", wait_b, 40);
          busy_b = 1'b0;
        end
      end
      if (cyc < 2900 && !busy_a && $urandom_range(0, 2) == 0) begin
        ea_wr = 1'($urandom); ea_addr = {1'b0, 6'($urandom)}; ea_dat = 8'($urandom);
        a_req = 1'b1; a_wr = ea_wr; a_addr = ea_addr; a_wdat = ea_dat;
        busy_a = 1'b1; wait_a = 0;
      end
      if (cyc < 2900 && !busy_b && $urandom_range(0, 2) == 0) begin
        eb_wr = 1'($urandom); eb_addr = {1'b1, 6'($urandom)}; eb_dat = 8'($urandom);
        b_req = 1'b1; b_wr = eb_wr; b_addr = eb_addr; b_wdat = eb_dat;
        busy_b = 1'b1; wait_b = 0; a_since_b = 0;
      end
    end
    chk("rand_drain", {busy_a, busy_b}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
